// File: rtl/pipe_flow_controller.sv
// rtl/pipe_flow_controller.sv - pipeline step/stall/progress generation with run/halt/step control
// Management FSM, memory-busy watchdog and saturating stall counter for a PIPE_STAGES-deep core.
module pipe_flow_controller #(
  parameter int PIPE_STAGES       = 3,
  parameter int TIMEOUT_WIDTH     = 8,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         management_run,
  input  logic                         management_halt,
  input  logic                         management_step,
  input  logic                         management_clear,
  input  logic                         stateExecute,
  input  logic                         requestingInstruction,
  input  logic                         instructionBusy,
  input  logic                         requestingData,
  input  logic                         dataBusy,
  input  logic [TIMEOUT_WIDTH-1:0]     busyTimeout,
  input  logic [PIPE_STAGES-1:0]       pipe_active,
  input  logic [PIPE_STAGES-1:0]       pipe_shouldStall,
  output logic                         stepPipe,
  output logic                         stallPipe,
  output logic                         progressPipe,
  output logic                         halted,
  output logic                         timeoutError,
  output logic [STALL_COUNT_WIDTH-1:0] stallCycles
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    DRAIN  = 2'd3
  } flowState_t;

  flowState_t                 state;
  flowState_t                 nextState;
  logic [TIMEOUT_WIDTH-1:0]   busyCount;
  logic [TIMEOUT_WIDTH:0]     busyCountPlusOne;
  logic                       blocked;
  logic                       anyStall;
  logic                       pipeActive;
  logic                       allow;
  logic                       issue;
  logic                       fire;
  logic                       stallInc;

  assign blocked      = (requestingInstruction & instructionBusy) | (requestingData & dataBusy);
  assign anyStall     = |pipe_shouldStall;
  assign pipeActive   = |pipe_active;
  assign allow        = (state == RUN) || (state == STEP);

  assign stepPipe     = stateExecute & ~blocked;
  assign stallPipe    = ~allow | anyStall;
  assign progressPipe = pipeActive | allow;
  assign halted       = (state == HALTED);
  assign issue        = stepPipe & ~stallPipe;

  // Compare one bit wider so a saturated busyCount can never alias onto the threshold.
  assign busyCountPlusOne = {1'b0, busyCount} + (TIMEOUT_WIDTH+1)'(1);
  assign fire = (busyTimeout != '0) && blocked && (busyCountPlusOne == {1'b0, busyTimeout});

  assign stallInc = stateExecute & (stallPipe | blocked) & (state != HALTED);

  always_comb begin
    nextState = state;
    case (state)
      HALTED: begin
        if (management_run)       nextState = RUN;
        else if (management_step) nextState = STEP;
      end
      RUN: begin
        if (management_halt) nextState = DRAIN;
      end
      STEP: begin
        if (issue || management_halt) nextState = DRAIN;
      end
      DRAIN: begin
        if (!pipeActive) nextState = HALTED;
      end
      default: nextState = HALTED;
    endcase
    // A stuck memory port pulls an executing core back into a drain regardless of requests.
    if (fire && ((state == RUN) || (state == STEP))) nextState = DRAIN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HALTED;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busyCount <= '0;
    end else if (fire) begin
      busyCount <= '0;
    end else if (stateExecute && blocked) begin
      if (busyCount != '1) busyCount <= busyCount + TIMEOUT_WIDTH'(1);
    end else begin
      busyCount <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   timeoutError <= 1'b0;
    else if (management_clear) timeoutError <= 1'b0;
    else if (fire)             timeoutError <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycles <= '0;
    end else if (management_clear) begin
      stallCycles <= '0;
    end else if (stallInc && (stallCycles != '1)) begin
      stallCycles <= stallCycles + STALL_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_flow_controller.sv
// tb/tb_pipe_flow_controller.sv - scoreboard bench for pipe_flow_controller
// Stimulus pushes expected output values; a negedge monitor pops and compares them.
module tb_pipe_flow_controller;

  localparam int PS = 3;
  localparam int TW = 8;
  localparam int SW = 16;

  localparam int S_STEP  = 0;
  localparam int S_STALL = 1;
  localparam int S_PROG  = 2;
  localparam int S_HALT  = 3;
  localparam int S_TERR  = 4;
  localparam int S_SC    = 5;
  localparam int S_SC4   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mRun, mHalt, mStep, mClear;
  logic          stateExecute, reqI, iBusy, reqD, dBusy;
  logic [TW-1:0] busyTimeout;
  logic [PS-1:0] pipeActive, pipeStall;

  logic          stepPipe, stallPipe, progressPipe, halted, timeoutError;
  logic [SW-1:0] stallCycles;
  logic          stepPipe4, stallPipe4, progressPipe4, halted4, timeoutError4;
  logic [3:0]    stallCycles4;

  pipe_flow_controller #(.PIPE_STAGES(PS), .TIMEOUT_WIDTH(TW), .STALL_COUNT_WIDTH(SW)) u_dut (
    .clk(clk), .rst(rst),
    .management_run(mRun), .management_halt(mHalt), .management_step(mStep), .management_clear(mClear),
    .stateExecute(stateExecute), .requestingInstruction(reqI), .instructionBusy(iBusy),
    .requestingData(reqD), .dataBusy(dBusy), .busyTimeout(busyTimeout),
    .pipe_active(pipeActive), .pipe_shouldStall(pipeStall),
    .stepPipe(stepPipe), .stallPipe(stallPipe), .progressPipe(progressPipe),
    .halted(halted), .timeoutError(timeoutError), .stallCycles(stallCycles)
  );

  pipe_flow_controller #(.PIPE_STAGES(PS), .TIMEOUT_WIDTH(TW), .STALL_COUNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .management_run(mRun), .management_halt(mHalt), .management_step(mStep), .management_clear(mClear),
    .stateExecute(stateExecute), .requestingInstruction(reqI), .instructionBusy(iBusy),
    .requestingData(reqD), .dataBusy(dBusy), .busyTimeout(busyTimeout),
    .pipe_active(pipeActive), .pipe_shouldStall(pipeStall),
    .stepPipe(stepPipe4), .stallPipe(stallPipe4), .progressPipe(progressPipe4),
    .halted(halted4), .timeoutError(timeoutError4), .stallCycles(stallCycles4)
  );

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input int s, input int v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic int actualOf(input int s);
    case (s)
      S_STEP:  return int'(stepPipe);
      S_STALL: return int'(stallPipe);
      S_PROG:  return int'(progressPipe);
      S_HALT:  return int'(halted);
      S_TERR:  return int'(timeoutError);
      S_SC:    return int'(stallCycles);
      S_SC4:   return int'(stallCycles4);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act;
      e   = sb.pop_front();
      act = actualOf(e.sel);
      checks++;
      if (act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mRun = 1'b0; mHalt = 1'b0; mStep = 1'b0; mClear = 1'b0;
    stateExecute = 1'b0; reqI = 1'b0; iBusy = 1'b0; reqD = 1'b0; dBusy = 1'b0;
    busyTimeout = '0; pipeActive = '0; pipeStall = '0;
    adv();
    adv();

    rst = 1'b0;
    chk("rst_halted", S_HALT, 1);
    chk("rst_stall", S_STALL, 1);
    chk("rst_terr", S_TERR, 0);
    chk("rst_sc", S_SC, 0);
    chk("rst_step", S_STEP, 0);
    chk("rst_prog", S_PROG, 0);
    adv();

    mRun = 1'b1; stateExecute = 1'b1;
    chk("run_pre_halted", S_HALT, 1);
    chk("run_pre_step", S_STEP, 1);
    chk("run_pre_stall", S_STALL, 1);
    adv();
    chk("run_halted", S_HALT, 0);
    chk("run_stall", S_STALL, 0);
    chk("run_step", S_STEP, 1);
    chk("run_prog", S_PROG, 1);
    chk("run_sc", S_SC, 0);
    adv();
    mRun = 1'b0;
    chk("run_level_sc", S_SC, 0);
    chk("run_level_halted", S_HALT, 0);
    adv();

    for (int i = 0; i < 10; i++) begin
      pipeStall = 3'b010;
      chk("stall_pipe", S_STALL, 1);
      chk("stall_cnt", S_SC, i);
      adv();
    end
    pipeStall = '0;
    chk("stall_total", S_SC, 10);
    chk("stall_total4", S_SC4, 10);
    chk("stall_release", S_STALL, 0);
    adv();
    mClear = 1'b1;
    chk("clear_pre_sc", S_SC, 10);
    adv();
    mClear = 1'b0;
    chk("clear_sc", S_SC, 0);
    chk("clear_sc4", S_SC4, 0);
    chk("clear_terr", S_TERR, 0);
    adv();

    for (int i = 0; i < 20; i++) begin
      pipeStall = 3'b001;
      chk("sat_sc4", S_SC4, (i > 15) ? 15 : i);
      adv();
    end
    pipeStall = '0;
    chk("sat_final4", S_SC4, 15);
    chk("sat_final16", S_SC, 20);
    adv();
    mClear = 1'b1;
    adv();
    mClear = 1'b0;

    busyTimeout = 8'd5; reqD = 1'b1; dBusy = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      chk("wd_terr_low", S_TERR, 0);
      chk("wd_halted", S_HALT, 0);
      chk("wd_step", S_STEP, 0);
      adv();
    end
    chk("wd_terr_set", S_TERR, 1);
    chk("wd_drain_halted", S_HALT, 0);
    chk("wd_drain_stall", S_STALL, 1);
    adv();
    reqD = 1'b0; dBusy = 1'b0;
    chk("wd_halted_after", S_HALT, 1);
    chk("wd_terr_sticky", S_TERR, 1);
    adv();
    mClear = 1'b1;
    adv();
    mClear = 1'b0; mRun = 1'b1;
    chk("wd_clear_terr", S_TERR, 0);
    adv();

    mRun = 1'b0; busyTimeout = '0; reqD = 1'b1; dBusy = 1'b1;
    for (int b = 0; b < 8; b++) begin
      chk("nowd_halted", S_HALT, 0);
      chk("nowd_terr", S_TERR, 0);
      adv();
    end
    reqD = 1'b0; dBusy = 1'b0;
    chk("nowd_terr_end", S_TERR, 0);
    chk("nowd_sc", S_SC, 8);
    adv();

    reqD = 1'b1; dBusy = 1'b1;
    adv();
    adv();
    adv();
    rst = 1'b1; pipeActive = 3'b100; reqD = 1'b0; dBusy = 1'b0;
    chk("midrst_pre_sc", S_SC, 11);
    chk("midrst_pre_halted", S_HALT, 0);
    adv();
    rst = 1'b0;
    chk("midrst_halted", S_HALT, 1);
    chk("midrst_sc", S_SC, 0);
    chk("midrst_terr", S_TERR, 0);
    chk("midrst_stall", S_STALL, 1);
    chk("midrst_prog", S_PROG, 1);
    adv();

    pipeActive = '0; mStep = 1'b1;
    chk("step_req_halted", S_HALT, 1);
    chk("step_req_stall", S_STALL, 1);
    chk("step_req_prog", S_PROG, 0);
    adv();
    mStep = 1'b0;
    chk("step_issue_halted", S_HALT, 0);
    chk("step_issue_stall", S_STALL, 0);
    chk("step_issue_step", S_STEP, 1);
    adv();
    pipeActive = 3'b001; mStep = 1'b1;
    chk("drain_step_stall", S_STALL, 1);
    chk("drain_step_halted", S_HALT, 0);
    adv();
    mStep = 1'b0; pipeActive = 3'b010;
    chk("drain2_stall", S_STALL, 1);
    chk("drain2_halted", S_HALT, 0);
    adv();
    pipeActive = '0;
    chk("drain3_stall", S_STALL, 1);
    chk("drain3_halted", S_HALT, 0);
    adv();
    chk("step_done_halted", S_HALT, 1);
    chk("step_done_stall", S_STALL, 1);
    adv();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flow_controller.md
Name: pipe_flow_controller

Overview:
- Parametrised successor to the core's three-stage flow-control logic.
- Generates stepPipe/stallPipe/progressPipe for a PIPE_STAGES-deep core pipeline.
- Adds an internal management run/halt/single-step state machine with pipeline drain, a memory-busy watchdog with a sticky error, and a saturating stall-cycle counter for debug.
- Sits between the management interface, the fetch/load-store memory ports and the pipeline stage registers.

Parameters:
- PIPE_STAGES, 3, number of pipeline stages reporting active/shouldStall (≥1).
- TIMEOUT_WIDTH, 8, width of the busy watchdog counter and threshold.
- STALL_COUNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- management_run  in  1  level; request free-running execution
- management_halt  in  1  level; request halt (drain then stop)
- management_step  in  1  single-cycle pulse; execute exactly one instruction
- management_clear  in  1  pulse; clears timeoutError and stallCycles
- stateExecute  in  1  core is in execute state
- requestingInstruction  in  1  fetch port request
- instructionBusy  in  1  fetch port busy
- requestingData  in  1  load/store port request
- dataBusy  in  1  load/store port busy
- busyTimeout  in  TIMEOUT_WIDTH  watchdog threshold in cycles; 0 disables
- pipe_active  in  PIPE_STAGES  per-stage valid
- pipe_shouldStall  in  PIPE_STAGES  per-stage stall request
- stepPipe  out  1  advance pipeline this cycle
- stallPipe  out  1  insert bubble at stage 0
- progressPipe  out  1  pipeline has work or may accept work
- halted  out  1  FSM in HALTED
- timeoutError  out  1  sticky watchdog flag
- stallCycles  out  STALL_COUNT_WIDTH  saturating stall count

Behaviour:
- Derived signals:
  - blocked = (requestingInstruction & instructionBusy) | (requestingData & dataBusy)
  - anyStall = |pipe_shouldStall
  - pipeActive = |pipe_active
  - allow = (state==RUN) | (state==STEP)
- Combinational outputs:
  - stepPipe = stateExecute & !blocked
  - stallPipe = !allow | anyStall
  - progressPipe = pipeActive | allow
  - halted = (state==HALTED)
- issue = stepPipe & !stallPipe (an instruction enters stage 0).
- FSM (registered; reset → HALTED):
  - HALTED: management_run → RUN; else management_step → STEP; halt ignored.
  - RUN: management_halt → DRAIN.
  - STEP: issue → DRAIN; management_halt → DRAIN. While in STEP, a further management_step pulse is ignored.
  - DRAIN: pipeActive==0 → HALTED. run/step are ignored until HALTED is reached.
  - Watchdog fire (see below) forces the next state to DRAIN from RUN or STEP, with priority over all other transitions.
- Watchdog:
  - busyCount (TIMEOUT_WIDTH) increments each cycle stateExecute & blocked; clears to 0 on any cycle without that condition.
  - fire when busyTimeout≠0 and busyCount+1 == busyTimeout while blocked.
  - fire sets timeoutError (sticky) and clears busyCount.
  - busyCount saturates at all-ones and never wraps.
- stallCycles:
  - Increments on each cycle stateExecute & (stallPipe | blocked) & state≠HALTED.
  - Saturates at 2^STALL_COUNT_WIDTH−1.
- management_clear:
  - Clears timeoutError and stallCycles next cycle.
  - Takes precedence over a simultaneous set/increment.
- Reset:
  - Synchronous; rst mid-operation returns the FSM to HALTED and zeroes busyCount, stallCycles and timeoutError on the next edge.
  - After reset: halted=1, stallPipe=1, timeoutError=0, stallCycles=0. stepPipe and progressPipe follow their input equations.
- With PIPE_STAGES=3, state held in RUN and no watchdog activity, stall/step/progress outputs match the original three-stage equations.

Test Plan:
- Reset, then management_run=1, stateExecute=1, no busy → halted falls next cycle; stallPipe=0, stepPipe=1, stallCycles stays 0.
- In HALTED, pulse management_step with pipe idle → exactly one issue cycle. FSM goes STEP→DRAIN; halted=1 once pipe_active returns to 0. A second step pulse during DRAIN produces no issue.
- RUN with requestingData=1, dataBusy=1 held, busyTimeout=5 → timeoutError rises on the 5th blocked cycle, FSM enters DRAIN. busyTimeout=0 with the same stimulus → no error.
- RUN with pipe_shouldStall[1]=1 for 10 cycles → stallPipe=1 for those cycles, stallCycles=10. management_clear → stallCycles=0, timeoutError=0.
- STALL_COUNT_WIDTH=4, continuous stall for 20 cycles → stallCycles saturates at 15.
- Assert rst in RUN with busyCount=3 → next cycle halted=1, counters 0; pipe_active nonzero → progressPipe=1 while stallPipe=1.
